mmm_inv_sched: RTL

MMM_INV_SCHED -- requirements
Module: mmm_inv_sched

---
 rtl/mmm_pkg.sv | 20 ++
 rtl/mmm_inv_sched_if.sv | 42 ++++
 rtl/mmm_rr_arb.sv | 35 +++
 rtl/mmm_inv_sched.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// Shared definitions for the modular-inverse request scheduler.
//   state_e       : scheduler FSM state encoding
//   DEFAULT_WIDTH : default operand width for N, R and results
//   rr_next()     : round-robin pointer advance (winner + 1, wrapping at n)
package mmm_pkg;

  localparam int DEFAULT_WIDTH = 260;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mmm_inv_sched_if.sv
// Bundle of request, inverse-engine and response signals of mmm_inv_sched.
//   slave  : the scheduler's view (consumes requests, drives the engine and responses)
//   master : the environment's view (requesters, inverse engine, response sink)
// Request side : req_valid, req_ready (one-hot grant), req_N (NREQ*WIDTH), req_neg, cfg_R
// Engine side  : inv_N, inv_R, inv_in_valid, inv_result, inv_out_valid
// Response side: rsp_valid, rsp_ready, rsp_id, rsp_result, rsp_err
interface mmm_inv_sched_if #(
  parameter int WIDTH = mmm_pkg::DEFAULT_WIDTH,
  parameter int NREQ  = 4
) ();

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_N;
  logic [NREQ-1:0]       req_neg;
  logic [WIDTH-1:0]      cfg_R;

  logic [WIDTH-1:0]      inv_N;
  logic [WIDTH-1:0]      inv_R;
  logic                  inv_in_valid;
  logic [WIDTH-1:0]      inv_result;
  logic                  inv_out_valid;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_N, req_neg, cfg_R, inv_result, inv_out_valid, rsp_ready,
    output req_ready, inv_N, inv_R, inv_in_valid, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport master (
    output req_valid, req_N, req_neg, cfg_R, inv_result, inv_out_valid, rsp_ready,
    input  req_ready, inv_N, inv_R, inv_in_valid, rsp_valid, rsp_id, rsp_result, rsp_err
  );

endinterface

// File: rtl/mmm_rr_arb.sv
// Combinational round-robin selector.
//   req   : request bits, one per requester
//   ptr   : index where the search starts (highest priority this cycle)
//   grant : one-hot winner (all zero when no request)
//   idx   : binary index of the winner (0 when no request)
module mmm_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  int j;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    grant = '0;
    idx   = '0;
    j     = 0;
    // Walk from the farthest offset toward ptr; the last hit (closest to ptr) wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NREQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/mmm_inv_sched.sv
// Schedules NREQ requesters onto one shared modular-inverse engine.
// One operation is outstanding at a time: IDLE grants a round-robin winner and
// latches its operands, ISSUE strobes the engine, WAIT collects the result (or
// times out after TIMEOUT cycles), RESP holds the response until accepted.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mmm_inv_sched_if.slave (requests, engine operands/result, response)
module mmm_inv_sched
  import mmm_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 2048
) (
  input  logic           clk,
  input  logic           rst_n,
  mmm_inv_sched_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  state_e           state;
  logic [IDW-1:0]   rr_ptr;
  logic [CW-1:0]    tmo_cnt;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] r_q;
  logic             neg_q;
  logic [IDW-1:0]   id_q;
  logic             in_valid_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_err_q;

  logic [NREQ-1:0]  win_grant;
  logic [IDW-1:0]   win_idx;
  logic [WIDTH-1:0] neg_res;

  mmm_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  // The grant is combinational so acceptance happens in the same IDLE cycle;
  // gating with rst_n keeps it low while reset is held.
  assign bus.req_ready = (rst_n && state == S_IDLE) ? win_grant : '0;

  // (R - x) mod R for x < R; zero maps to zero rather than R.
  assign neg_res = (bus.inv_result == '0) ? '0 : r_q - bus.inv_result;

  assign bus.inv_N        = n_q;
  assign bus.inv_R        = r_q;
  assign bus.inv_in_valid = in_valid_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_err      = rsp_err_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      tmo_cnt      <= '0;
      n_q          <= '0;
      r_q          <= '0;
      neg_q        <= 1'b0;
      id_q         <= '0;
      in_valid_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      in_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req_valid) begin
            n_q        <= bus.req_N[int'(win_idx)*WIDTH +: WIDTH];
            r_q        <= bus.cfg_R;
            neg_q      <= bus.req_neg[win_idx];
            id_q       <= win_idx;
            rr_ptr     <= IDW'(rr_next(int'(win_idx), NREQ));
            in_valid_q <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.inv_out_valid) begin
            rsp_result_q <= neg_q ? neg_res : bus.inv_result;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state        <= S_RESP;
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state        <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
